// File: rtl/lsu_byte_serial.sv
`default_nettype none
// ============================================================================
// Module      : lsu_byte_serial
// Description : Byte-serial RV32I load/store unit. Accepts one request
//               (address, funct3 width, store data). Moves one byte per
//               8-bit memory handshake, little-endian. Returns a
//               sign/zero-extended load word or completes a store.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_byte_serial #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] buf_q, buf_d;   // bytes gathered so far for a load
  logic [DATA_W-1:0] hold_q, hold_d; // last response word, held between responses

  logic              req_legal;
  logic              last_byte;
  logic [DATA_W-1:0] ext_word;

  // Request legality, last-byte detection and load-result extension
  always_comb begin
    req_legal = 1'b0;
    if (req_store) begin
      req_legal = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2);
    end else begin
      req_legal = (req_funct3 == 3'd0) || (req_funct3 == 3'd1) || (req_funct3 == 3'd2) ||
                  (req_funct3 == 3'd4) || (req_funct3 == 3'd5);
    end

    case (funct3_q[1:0])
      2'b00:   last_byte = (idx_q == 2'd0);
      2'b01:   last_byte = (idx_q == 2'd1);
      default: last_byte = (idx_q == 2'd3);
    endcase

    ext_word = '0;
    if (!store_q && !err_q) begin
      case (funct3_q)
        3'd0:    ext_word = {{(DATA_W-8){buf_q[7]}}, buf_q[7:0]};
        3'd1:    ext_word = {{(DATA_W-16){buf_q[15]}}, buf_q[15:0]};
        3'd4:    ext_word = {{(DATA_W-8){1'b0}}, buf_q[7:0]};
        3'd5:    ext_word = {{(DATA_W-16){1'b0}}, buf_q[15:0]};
        default: ext_word = buf_q;
      endcase
    end
  end

  // Next-state and output decode for IDLE -> ACCESS -> DONE sequencing
  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    funct3_d   = funct3_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    err_d      = err_q;
    buf_d      = buf_q;
    hold_d     = hold_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = hold_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'h00;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          base_d   = req_addr;
          wdata_d  = req_wdata;
          idx_d    = 2'd0;
          buf_d    = '0;
          err_d    = !req_legal;
          // Illegal widths skip memory entirely and report straight away
          state_d  = req_legal ? ST_ACCESS : ST_DONE;
        end
      end
      ST_ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = store_q;
        mem_addr  = base_q + ADDR_W'(idx_q);
        mem_wdata = wdata_q[{idx_q, 3'b000} +: 8];
        if (mem_ack) begin
          if (!store_q) begin
            buf_d[{idx_q, 3'b000} +: 8] = mem_rdata;
          end
          idx_d = idx_q + 2'd1;
          if (last_byte) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = ext_word;
        hold_d     = ext_word;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      base_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= 2'd0;
      err_q    <= 1'b0;
      buf_q    <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      buf_q    <= buf_d;
      hold_q   <= hold_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_byte_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_byte_serial
// Description : Directed self-checking bench for lsu_byte_serial with a
//               256-byte memory model and an ack generator that can insert
//               a programmable number of wait cycles per byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_byte_serial;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:255];
  int          ack_wait;
  int          wait_cnt;
  logic [31:0] log_addr [0:63];
  logic [7:0]  log_data [0:63];
  logic        log_we   [0:63];
  int          log_n;
  int          stab_err;
  logic        pend;
  logic [31:0] p_addr;
  logic [7:0]  p_wdata;
  logic        p_we;
  logic        ever_resp;

  lsu_byte_serial #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  assign mem_ack   = mem_req && (wait_cnt == ack_wait);

  // Wait-cycle counter, access log and hold-stable monitor
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else                     wait_cnt <= 0;
    if (mem_req && mem_ack) begin
      log_addr[log_n[5:0]] <= mem_addr;
      log_data[log_n[5:0]] <= mem_wdata;
      log_we[log_n[5:0]]   <= mem_we;
      log_n                <= log_n + 1;
    end
    if (pend && mem_req && ((mem_addr !== p_addr) || (mem_we !== p_we) || (mem_wdata !== p_wdata)))
      stab_err <= stab_err + 1;
    pend    <= mem_req && !mem_ack;
    p_addr  <= mem_addr;
    p_we    <= mem_we;
    p_wdata <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for its response; cyc counts from accept = 0
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int cyc, output logic [31:0] rd,
                        output logic er);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_store  = ~st;
    req_funct3 = 3'd7;
    req_addr   = 32'h0000_0000;
    req_wdata  = 32'h5A5A_A5A5;
    cyc = 1;
    while (!resp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("resp_valid_seen", {31'b0, resp_valid}, 32'd1);
    rd = resp_rdata;
    er = resp_err;
  endtask

  initial begin
    int          cyc;
    int          start;
    logic [31:0] rd;
    logic        er;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h80] = 8'h58;
    mem[8'h10] = 8'hF0;
    mem[8'h21] = 8'h80;
    mem[8'hFF] = 8'h34;
    mem[8'h00] = 8'h12;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    ack_wait   = 0;
    wait_cnt   = 0;
    log_n      = 0;
    stab_err   = 0;
    pend       = 1'b0;
    p_addr     = 32'h0;
    p_we       = 1'b0;
    p_wdata    = 8'h0;
    #22;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err",   {31'b0, resp_err},   32'd0);
    chk("rst_resp_rdata", resp_rdata,          32'd0);
    chk("rst_mem_req",    {31'b0, mem_req},    32'd0);
    chk("rst_mem_we",     {31'b0, mem_we},     32'd0);
    chk("rst_mem_addr",   mem_addr,            32'd0);
    chk("rst_mem_wdata",  {24'b0, mem_wdata},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);

    // lw at 0x80, ack tied high
    start = log_n;
    do_req(1'b0, 3'd2, 32'h0000_0080, 32'h0, cyc, rd, er);
    chk("lw_rdata", rd, 32'h0000_0058);
    chk("lw_cycle", cyc, 32'd5);
    chk("lw_err", {31'b0, er}, 32'd0);
    chk("lw_nacc", log_n - start, 32'd4);
    for (int k = 0; k < 4; k++) chk("lw_addr", log_addr[(start + k) % 64], 32'h80 + k);

    // lb / lbu of 0xF0
    start = log_n;
    do_req(1'b0, 3'd0, 32'h0000_0010, 32'h0, cyc, rd, er);
    chk("lb_rdata", rd, 32'hFFFF_FFF0);
    chk("lb_cycle", cyc, 32'd2);
    chk("lb_nacc", log_n - start, 32'd1);
    start = log_n;
    do_req(1'b0, 3'd4, 32'h0000_0010, 32'h0, cyc, rd, er);
    chk("lbu_rdata", rd, 32'h0000_00F0);
    chk("lbu_nacc", log_n - start, 32'd1);
    repeat (3) @(negedge clk);
    chk("rdata_hold", resp_rdata, 32'h0000_00F0);

    // lh sign-extension from bit 15
    do_req(1'b0, 3'd1, 32'h0000_0020, 32'h0, cyc, rd, er);
    chk("lh_rdata", rd, 32'hFFFF_8000);
    chk("lh_cycle", cyc, 32'd3);

    // lhu across the address wrap
    start = log_n;
    do_req(1'b0, 3'd5, 32'hFFFF_FFFF, 32'h0, cyc, rd, er);
    chk("lhu_wrap_rdata", rd, 32'h0000_1234);
    chk("lhu_wrap_addr0", log_addr[start % 64], 32'hFFFF_FFFF);
    chk("lhu_wrap_addr1", log_addr[(start + 1) % 64], 32'h0000_0000);

    // sw with two wait cycles per byte
    ack_wait = 2;
    start = log_n;
    do_req(1'b1, 3'd2, 32'h0000_007B, 32'hDEAD_BEEF, cyc, rd, er);
    chk("sw_cycle", cyc, 32'd13);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", {31'b0, er}, 32'd0);
    chk("sw_nacc", log_n - start, 32'd4);
    chk("sw_bytes", {log_data[(start + 3) % 64], log_data[(start + 2) % 64],
                     log_data[(start + 1) % 64], log_data[start % 64]}, 32'hDEAD_BEEF);
    for (int k = 0; k < 4; k++) begin
      chk("sw_addr", log_addr[(start + k) % 64], 32'h7B + k);
      chk("sw_we", {31'b0, log_we[(start + k) % 64]}, 32'd1);
    end
    chk("hold_stable", stab_err, 32'd0);
    ack_wait = 0;

    // sb writes one byte only
    start = log_n;
    do_req(1'b1, 3'd0, 32'h0000_0040, 32'h1234_56A7, cyc, rd, er);
    chk("sb_nacc", log_n - start, 32'd1);
    chk("sb_byte", {24'b0, log_data[start % 64]}, 32'h0000_00A7);
    chk("sb_cycle", cyc, 32'd2);

    // illegal widths: store funct3=4, load funct3=3
    start = log_n;
    do_req(1'b1, 3'd4, 32'h0000_0080, 32'hFFFF_FFFF, cyc, rd, er);
    chk("ill_st_err", {31'b0, er}, 32'd1);
    chk("ill_st_cycle", cyc, 32'd1);
    chk("ill_st_rdata", rd, 32'h0);
    do_req(1'b0, 3'd3, 32'h0000_0080, 32'h0, cyc, rd, er);
    chk("ill_ld_err", {31'b0, er}, 32'd1);
    chk("ill_ld_cycle", cyc, 32'd1);
    chk("ill_nacc", log_n - start, 32'd0);

    // reset in the middle of a lw after two byte acks
    do_req(1'b0, 3'd2, 32'h0000_0080, 32'h0, cyc, rd, er);
    start = log_n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0080;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_nacc",  log_n - start,       32'd2);
    chk("mid_rst_req",   {31'b0, mem_req},    32'd0);
    chk("mid_rst_addr",  mem_addr,            32'd0);
    chk("mid_rst_we",    {31'b0, mem_we},     32'd0);
    chk("mid_rst_wdata", {24'b0, mem_wdata},  32'd0);
    chk("mid_rst_rdata", resp_rdata,          32'd0);
    ever_resp = resp_valid | resp_err;
    repeat (2) begin
      @(negedge clk);
      ever_resp = ever_resp | resp_valid | resp_err;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ever_resp = ever_resp | resp_valid;
    end
    chk("mid_rst_no_resp", {31'b0, ever_resp}, 32'd0);
    do_req(1'b0, 3'd2, 32'h0000_0080, 32'h0, cyc, rd, er);
    chk("post_rst_rdata", rd, 32'h0000_0058);
    chk("post_rst_cycle", cyc, 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
